// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, result word type and a constant clog2 helper.
package alu_pkg;
  localparam int DATA_SIZE = 16;
  typedef logic [DATA_SIZE:0] res_word_t;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) ;
    return r;
  endfunction
endpackage

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p: register array with one synchronous write port and one asynchronous read port.
module fifo_mem_2p #(
  parameter int W     = 17,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: FWFT result buffer for adder {c_out, s} words.
// Occupancy lives in count; ready is registered from next count so it never sees res_ready combinationally.
module alu_result_fifo #(
  parameter int DATA_SIZE = alu_pkg::DATA_SIZE,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = alu_pkg::clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE-1:0] s,
  input  logic                 c_out,
  input  logic                 valid_f_res,
  output logic                 ready_t_res,
  output logic [DATA_SIZE:0]   res_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty
);
  localparam int PW = alu_pkg::clog2(DEPTH);
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic ready_q, push, pop;
  logic [DATA_SIZE:0] rd_data;
  assign push = valid_f_res & ready_q;
  assign pop  = res_valid & res_ready;
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= count_d != CNT_W'(DEPTH);
    end
  fifo_mem_2p #(.W(DATA_SIZE + 1), .DEPTH(DEPTH), .AW(PW)) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i ({c_out, s}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );
  assign count       = count_q;
  assign full        = count_q == CNT_W'(DEPTH);
  assign empty       = count_q == '0;
  assign res_valid   = !empty;
  assign res_data    = empty ? '0 : rd_data;
  assign ready_t_res = ready_q;
endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed and random stimulus checked against a queue-based reference model.
module tb_alu_result_fifo;
  import alu_pkg::*;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DATA_SIZE-1:0] s = '0;
  logic c_out = 1'b0;
  logic valid_f_res = 1'b0;
  logic ready_t_res;
  res_word_t res_data;
  logic res_valid;
  logic res_ready = 1'b0;
  logic [CNT_W-1:0] count;
  logic full, empty;
  int n_chk = 0;
  int n_fail = 0;
  res_word_t mq[$];
  logic rdy_m = 1'b0;
  logic acc_m = 1'b0;

  alu_result_fifo #(.DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .s(s), .c_out(c_out), .valid_f_res(valid_f_res),
    .ready_t_res(ready_t_res), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Reference: a queue of accepted words; ready follows occupancy one edge later.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mq.delete();
      rdy_m = 1'b0;
      acc_m = 1'b0;
    end else begin
      acc_m = valid_f_res && rdy_m;
      if (mq.size() > 0 && res_ready) void'(mq.pop_front());
      if (acc_m) mq.push_back({c_out, s});
      rdy_m = mq.size() < DEPTH;
    end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("ready", 32'(ready_t_res), 32'(rdy_m));
    chk("valid", 32'(res_valid), 32'(mq.size() != 0));
    chk("data", 32'(res_data), mq.size() != 0 ? 32'(mq[0]) : 32'd0);
    chk("count", 32'(count), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("cnt_bound", 32'(count <= DEPTH), 32'd1);
  endtask

  task automatic step(input logic v, input logic [DATA_SIZE-1:0] d, input logic c, input logic rr);
    valid_f_res = v;
    s = d;
    c_out = c;
    res_ready = rr;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    int exp_seq, nxt;
    res_word_t hold;
    logic hv, rr;
    valid_f_res = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready_t_res), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    valid_f_res = 1'b0;
    rst_n = 1'b1;
    step(0, '0, 0, 0);
    chk("rel_ready", 32'(ready_t_res), 32'd1);
    step(1, 16'h00F3, 0, 1);
    chk("single_data", 32'(res_data), 32'h000F3);
    step(0, '0, 0, 1);
    chk("single_cnt", 32'(count), 32'd0);
    for (int k = 1; k <= 4; k++) step(1, DATA_SIZE'(k), 0, 0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ready", 32'(ready_t_res), 32'd0);
    step(1, 16'h0005, 0, 0);
    chk("fill_hold", 32'(res_data), 32'h00001);
    exp_seq = 1;
    nxt = 5;
    for (int i = 0; i < 20; i++) begin
      if (res_valid) begin
        chk("order", 32'(res_data), 32'(exp_seq));
        exp_seq++;
      end
      step(nxt <= 8, DATA_SIZE'(nxt), 0, 1);
      if (i == 0) chk("ready_recover", 32'(ready_t_res), 32'd1);
      if (acc_m) nxt++;
    end
    chk("drain_done", 32'(exp_seq), 32'd9);
    step(1, 16'hFFFF, 1, 0);
    chk("carry", 32'(res_data), 32'h1FFFF);
    repeat (2) step(0, '0, 0, 1);
    for (int k = 0; k < 3; k++) step(1, DATA_SIZE'($urandom), 1'($urandom), 0);
    for (int i = 0; i < 12; i++) begin
      rr = 1'($urandom);
      hold = res_data;
      hv = res_valid;
      step(0, '0, 0, rr);
      if (hv && !rr) chk("stable", 32'(res_data), 32'(hold));
    end
    for (int k = 0; k < 2; k++) step(1, DATA_SIZE'($urandom), 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(res_valid), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_empty", 32'(empty), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, '0, 0, 0);
    for (int i = 0; i < 200; i++)
      step(1'($urandom), DATA_SIZE'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
